// File: rtl/chip_order.sv
// chip_order: sequences a colour-chip order (red, then green, then blue) through a handshaking dispenser.
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   go                  one-cycle order request, accepted only when idle
//   red/green/blue_count  chips per colour, sampled with go
//   complete            dispenser done flag (cleared by the dispenser on any dispense change)
//   start               dispenser enable
//   dispense            colour code 00 red, 01 green, 10 blue, 11 idle
//   busy, done          order in progress / one-cycle end-of-order pulse
//   error               order ended by timeout, held until the next accepted go
//   chips_left          remaining red+green+blue chips
// Optional: define CHIP_ORDER_TIMEOUT_EN to bound each dispenser wait by TIMEOUT_CYCLES.
module chip_order #(
  parameter int TIMEOUT_CYCLES = 75000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       go,
  input  logic [3:0] red_count,
  input  logic [3:0] green_count,
  input  logic [3:0] blue_count,
  input  logic       complete,
  output logic       start,
  output logic [1:0] dispense,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [5:0] chips_left
);
  typedef enum logic [2:0] {IDLE, SELECT, ISSUE, WAIT_CLR, WAIT_DONE, RELEASE, FINISH} state_t;
  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 134217728) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must fit the 27-bit timeout counter");
  end
  state_t state_q, state_d;
  logic [3:0] red_q, red_d, grn_q, grn_d, blu_q, blu_d;
  logic [1:0] sel_q, sel_d;
  logic       tmo_hit;
  always_comb begin
    state_d = state_q;
    red_d = red_q;
    grn_d = grn_q;
    blu_d = blu_q;
    sel_d = sel_q;
    case (state_q)
      IDLE: if (go) begin
        red_d = red_count;
        grn_d = green_count;
        blu_d = blue_count;
        state_d = SELECT;
      end
      SELECT: begin
        sel_d = red_q != 4'd0 ? 2'b00 : grn_q != 4'd0 ? 2'b01 : 2'b10;
        state_d = (red_q | grn_q | blu_q) == 4'd0 ? FINISH : ISSUE;
      end
      ISSUE: state_d = WAIT_CLR;
      WAIT_CLR: state_d = !complete ? WAIT_DONE : tmo_hit ? FINISH : WAIT_CLR;
      WAIT_DONE: if (complete) begin
        red_d = (sel_q == 2'b00 && red_q != 4'd0) ? red_q - 4'd1 : red_q;
        grn_d = (sel_q == 2'b01 && grn_q != 4'd0) ? grn_q - 4'd1 : grn_q;
        blu_d = (sel_q == 2'b10 && blu_q != 4'd0) ? blu_q - 4'd1 : blu_q;
        state_d = RELEASE;
      end else if (tmo_hit) begin
        state_d = FINISH;
      end
      RELEASE: state_d = SELECT;
      FINISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      red_q <= '0;
      grn_q <= '0;
      blu_q <= '0;
      sel_q <= 2'b11;
    end else begin
      state_q <= state_d;
      red_q <= red_d;
      grn_q <= grn_d;
      blu_q <= blu_d;
      sel_q <= sel_d;
    end
  end
`ifdef CHIP_ORDER_TIMEOUT_EN
  logic [26:0] tmo_q, tmo_d;
  logic        err_q, err_d;
  logic        waiting;
  assign waiting = state_q inside {WAIT_CLR, WAIT_DONE};
  assign tmo_hit = waiting && tmo_q == 27'(TIMEOUT_CYCLES - 1);
  // counter restarts on every entry into a wait state
  always_comb begin
    tmo_d = (waiting && state_d == state_q) ? tmo_q + 27'd1 : 27'd0;
    err_d = (state_q == IDLE && go) ? 1'b0 : (tmo_hit && state_d == FINISH) ? 1'b1 : err_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      tmo_q <= '0;
      err_q <= 1'b0;
    end else begin
      tmo_q <= tmo_d;
      err_q <= err_d;
    end
  end
  assign error = err_q;
`else
  assign tmo_hit = 1'b0;
  assign error = 1'b0;
`endif
  // dispense drops to 11 in RELEASE so a repeat colour is still seen as a code change
  assign start = state_q inside {ISSUE, WAIT_CLR, WAIT_DONE, RELEASE};
  assign dispense = state_q inside {ISSUE, WAIT_CLR, WAIT_DONE} ? sel_q : 2'b11;
  assign busy = state_q != IDLE && state_q != FINISH;
  assign done = state_q == FINISH;
  assign chips_left = {2'b00, red_q} + {2'b00, grn_q} + {2'b00, blu_q};
endmodule

// File: tb/tb_chip_order.sv
// tb_chip_order: table, random and corner-case checks of chip_order against a dispenser and order model.
module tb_chip_order;
`ifdef CHIP_ORDER_TIMEOUT_EN
  localparam int TMO = 100;
`else
  localparam int TMO = 75000000;
`endif
  logic clk = 1'b0, reset = 1'b1, go = 1'b0, complete = 1'b0;
  logic [3:0] red_count = '0, green_count = '0, blue_count = '0;
  logic start, busy, done, error;
  logic [1:0] dispense;
  logic [5:0] chips_left;
  int checks = 0, failures = 0;
  bit disp_en = 1'b1;
  int rises = 0;
  chip_order #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset), .go(go), .red_count(red_count), .green_count(green_count),
    .blue_count(blue_count), .complete(complete), .start(start), .dispense(dispense),
    .busy(busy), .done(done), .error(error), .chips_left(chips_left)
  );
  always #5 clk = ~clk;
  // dispenser: complete clears on any code change, rises after 20 enabled cycles on a valid code
  logic [1:0] d_prev = 2'b11;
  int d_cnt = 0;
  always @(negedge clk) begin
    if (dispense != d_prev) begin
      complete = 1'b0;
      d_cnt = 0;
    end else if (start && dispense != 2'b11 && !complete && disp_en) begin
      d_cnt++;
      if (d_cnt == 20) begin
        complete = 1'b1;
        rises++;
      end
    end
    d_prev = dispense;
  end
  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask
  // call right after a negedge; drives go in the current cycle and follows the order to done
  task automatic run_order(input logic [3:0] r, g, b, input bit poke, output int cyc_done,
                           output int busy_cyc, output bit start_seen, output int left1);
    logic [1:0] dq[$], eq[$];
    logic [5:0] lq[$], el[$];
    logic [1:0] pd;
    logic [5:0] pl;
    int tot, r0;
    red_count = r; green_count = g; blue_count = b; go = 1'b1;
    pd = dispense; pl = chips_left; r0 = rises;
    cyc_done = -1; busy_cyc = 0; start_seen = 0; left1 = -1;
    for (int k = 1; k <= 3000 && cyc_done < 0; k++) begin
      @(negedge clk);
      go = 1'b0;
      if (poke && k == 3) begin
        go = 1'b1;
        red_count = 4'($urandom_range(1, 15));
        green_count = 4'($urandom_range(1, 15));
        blue_count = 4'($urandom_range(1, 15));
      end
      if (k == 1) left1 = int'(chips_left);
      if (dispense != pd) dq.push_back(dispense);
      if (chips_left != pl) lq.push_back(chips_left);
      pd = dispense; pl = chips_left;
      if (busy) busy_cyc++;
      if (start) start_seen = 1;
      if (done) cyc_done = k;
    end
    go = 1'b0;
    tot = int'(r) + int'(g) + int'(b);
    for (int i = 0; i < int'(r); i++) begin eq.push_back(2'b00); eq.push_back(2'b11); end
    for (int i = 0; i < int'(g); i++) begin eq.push_back(2'b01); eq.push_back(2'b11); end
    for (int i = 0; i < int'(b); i++) begin eq.push_back(2'b10); eq.push_back(2'b11); end
    for (int i = tot; i >= 0; i--) if (i != 0 || tot != 0) el.push_back(6'(i));
    if (tot > 0 && el[0] == 6'(int'(chips_left) + 0) && 0) el.delete(0);
    chk("done_seen", cyc_done >= 0, 1);
    chk("error_at_done", error, 0);
    chk("chips_left_end", chips_left, 0);
    chk("rises", rises - r0, tot);
    chk("disp_seq_len", dq.size(), eq.size());
    for (int i = 0; i < dq.size() && i < eq.size(); i++)
      if (dq[i] != eq[i]) chk($sformatf("disp_seq[%0d]", i), dq[i], eq[i]);
    chk("left_seq_len", lq.size(), el.size());
    for (int i = 0; i < lq.size() && i < el.size(); i++)
      if (lq[i] != el[i]) chk($sformatf("left_seq[%0d]", i), lq[i], el[i]);
    @(negedge clk);
    chk("done_one_pulse", done, 0);
    chk("busy_after", busy, 0);
  endtask
  typedef struct {
    logic [3:0] r, g, b;
    bit         poke;
    int         exp_done;
    int         exp_left1;
  } vec_t;
  vec_t tbl[6];
  int cd, bc, l1, tot;
  bit ss;
  initial begin
    tbl[0] = '{4'd2, 4'd0, 4'd1, 1'b0, 71, 3};
    tbl[1] = '{4'd0, 4'd0, 4'd0, 1'b0, 2, 0};
    tbl[2] = '{4'd0, 4'd3, 4'd0, 1'b0, 71, 3};
    tbl[3] = '{4'd1, 4'd1, 4'd1, 1'b1, 71, 3};
    tbl[4] = '{4'd0, 4'd0, 4'd2, 1'b1, 48, 2};
    tbl[5] = '{4'd15, 4'd15, 4'd15, 1'b0, 1037, 45};
    repeat (3) @(negedge clk);
    chk("rst_start", start, 0);
    chk("rst_dispense", dispense, 3);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_chips_left", chips_left, 0);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      run_order(tbl[i].r, tbl[i].g, tbl[i].b, tbl[i].poke, cd, bc, ss, l1);
      chk($sformatf("tbl%0d_done_cycle", i), cd, tbl[i].exp_done);
      chk($sformatf("tbl%0d_busy_cycles", i), bc, tbl[i].exp_done - 1);
      chk($sformatf("tbl%0d_start_seen", i), ss, tbl[i].exp_left1 != 0);
      chk($sformatf("tbl%0d_left_after_go", i), l1, tbl[i].exp_left1);
    end
    for (int n = 0; n < 15; n++) begin
      logic [3:0] r, g, b;
      r = 4'($urandom_range(0, 3)); g = 4'($urandom_range(0, 3)); b = 4'($urandom_range(0, 3));
      tot = int'(r) + int'(g) + int'(b);
      run_order(r, g, b, 1'($urandom_range(0, 1)), cd, bc, ss, l1);
      chk("rnd_done_cycle", cd, 23 * tot + 2);
      chk("rnd_busy_cycles", bc, 23 * tot + 1);
      chk("rnd_left_after_go", l1, tot);
    end
    // reset during the second of four red chips
    red_count = 4'd4; green_count = 4'd0; blue_count = 4'd0; go = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      go = 1'b0;
      if (done) chk("rst_mid_early_done", done, 0);
    end
    chk("rst_mid_in_wait", {start, dispense}, {1'b1, 2'b00});
    chk("rst_mid_left", chips_left, 3);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_mid_start", start, 0);
    chk("rst_mid_dispense", dispense, 3);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_done", done, 0);
    chk("rst_mid_chips_left", chips_left, 0);
    reset = 1'b0;
    run_order(4'd1, 4'd0, 4'd0, 1'b0, cd, bc, ss, l1);
    chk("rst_mid_next_done", cd, 25);
`ifdef CHIP_ORDER_TIMEOUT_EN
    @(negedge clk);
    disp_en = 1'b0;
    red_count = 4'd2; green_count = 4'd0; blue_count = 4'd0; go = 1'b1;
    cd = -1;
    for (int k = 1; k <= 400 && cd < 0; k++) begin
      @(negedge clk);
      go = 1'b0;
      if (done) cd = k;
    end
    chk("tmo_done_cycle", cd, 104);
    chk("tmo_error", error, 1);
    chk("tmo_chips_left", chips_left, 2);
    @(negedge clk);
    chk("tmo_error_held", error, 1);
    disp_en = 1'b1;
    go = 1'b1; red_count = 4'd1;
    @(negedge clk);
    go = 1'b0;
    chk("tmo_error_cleared", error, 0);
    for (int k = 0; k < 60 && busy; k++) @(negedge clk);
    chk("tmo_recover_idle", busy, 0);
`endif
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/chip_order.md
CHIP_ORDER -- requirements
Module: chip_order

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 75000000, SHALL set the per-chip completion timeout in clk cycles (1.5 s at 50 MHz).
REQ-002 clk  input  1  system clock; all logic SHALL be on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset; one clock; reset is synchronous and active-high.
REQ-004 go  input  1  one-cycle order request, sampled only in IDLE.
REQ-005 red_count, green_count, blue_count  input  4 each  chips of each colour to dispense, sampled with go.
REQ-006 complete  input  1  dispenser done flag; high after a chip finishes; cleared by the dispenser when the dispense code changes.
REQ-007 start  output  1  dispenser enable; the dispenser freezes its sequence while low.
REQ-008 dispense  output  2  colour code: 00 red, 01 green, 10 blue, 11 idle/no request.
REQ-009 busy  output  1  high while an order is in progress.
REQ-010 done  output  1  one-cycle pulse when an order ends.
REQ-011 error  output  1  high when an order ended by timeout; held until the next accepted go or reset.
REQ-012 chips_left  output  6  sum of remaining red+green+blue chips.

Function
REQ-013 States SHALL be IDLE, SELECT, ISSUE, WAIT_CLR, WAIT_DONE, RELEASE, FINISH.
REQ-014 IDLE: go=1 SHALL load the three remaining counters, clear error, and enter SELECT; busy=1 from the next cycle; go outside IDLE SHALL be ignored.
REQ-015 SELECT: pick the first colour with a nonzero remaining count, in order red, green, blue -> ISSUE; all zero -> FINISH.
REQ-016 ISSUE (1 cycle): drive dispense=selected code, start=1 -> WAIT_CLR.
REQ-017 WAIT_CLR: wait for complete=0 (the dispenser has accepted the new code) -> WAIT_DONE.
REQ-018 WAIT_DONE: on complete=1, decrement that colour's counter by 1 -> RELEASE.
REQ-019 RELEASE (1 cycle): drive dispense=11 so the next code is always a change, even for the same colour -> SELECT.
REQ-020 start SHALL be 1 in ISSUE, WAIT_CLR, WAIT_DONE, and RELEASE, and 0 otherwise.
REQ-021 FINISH (1 cycle): done=1, start=0, dispense=11 -> IDLE; busy=0 from the next cycle.
REQ-022 Counters SHALL never decrement below 0; chips_left SHALL be a 6-bit zero-extended sum, maximum 45, updated the cycle after each decrement.
REQ-023 An all-zero order SHALL produce done two cycles after go (IDLE->SELECT->FINISH), with start never asserted.
REQ-024 Minimum per-chip overhead outside the dispenser SHALL be 4 cycles (SELECT, ISSUE, WAIT_CLR with complete already low, RELEASE).

Reset
REQ-025 Reset SHALL force state IDLE, start=0, dispense=11, busy=0, done=0, error=0, chips_left=0, timeout counter=0, and all remaining counters=0.
REQ-026 Reset mid-order SHALL abandon the order without a done pulse; a new go SHALL be accepted the first cycle after reset deasserts.

Configuration
REQ-027 Macro CHIP_ORDER_TIMEOUT_EN defined: a 27-bit counter SHALL run in WAIT_CLR and WAIT_DONE and SHALL clear on each state entry.
REQ-028 With CHIP_ORDER_TIMEOUT_EN, a count reaching TIMEOUT_CYCLES-1 without the awaited complete level SHALL set error=1 and enter FINISH; the remaining counters are kept.
REQ-029 Without CHIP_ORDER_TIMEOUT_EN, there SHALL be no timeout counter, error SHALL be tied 0, and the waits SHALL be unbounded.

Verification (dispenser behavioural model: complete drops 1 cycle after a dispense change, rises 20 cycles after start with a valid code)
REQ-030 reset, then go with red=2, green=0, blue=1 -> dispense sequence 00,11,00,11,10,11; done once; chips_left 3->2->1->0; error=0.
REQ-031 go with all counts 0 -> done high exactly 2 cycles after go; start stays 0; busy high for 1 cycle.
REQ-032 go with green=3 -> dispense passes through 11 between each 01; exactly 3 complete rises consumed; done after the third.
REQ-033 With CHIP_ORDER_TIMEOUT_EN and TIMEOUT_CYCLES=100, model never raises complete -> error=1 and done on the 100th WAIT_DONE cycle; chips_left unchanged; next go clears error.
REQ-034 reset asserted in WAIT_DONE of the 2nd of 4 red chips -> next cycle start=0, dispense=11, busy=0, no done; a following go with red=1 completes normally.
REQ-035 go pulsed again while busy -> ignored; counters and the dispense sequence are unaffected.
